pipe_ctrl_unit: RTL

Second-generation control unit for the 5-stage RV32I pipeline. Decodes the ID-stage instruction into the control bundle and registers it into the ID/EX boundary. Also owns hazard control:
- load-use stall insertion
- redirect flush
- optional multi-cycle M-extension stall
It replaces the purely combinational decoder and drives the IF/ID and PC hold and flush lines directly.

---
 rtl/pipe_ctrl_unit_pkg.sv | 35 +++
 rtl/pipe_ctrl_unit_decode.sv | 62 ++++++
 rtl/pipe_ctrl_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared RV32I opcode constants, the decoded control bundle and the M-extension stall states.
package pipe_ctrl_unit_pkg;

  localparam logic [6:0] OPCODE_R     = 7'b0110011;
  localparam logic [6:0] OPCODE_I     = 7'b0010011;
  localparam logic [6:0] OPCODE_L     = 7'b0000011;
  localparam logic [6:0] OPCODE_S     = 7'b0100011;
  localparam logic [6:0] OPCODE_B     = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL   = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR  = 7'b1100111;
  localparam logic [6:0] OPCODE_LUI   = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC = 7'b0010111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  typedef struct packed {
    logic       branch;
    logic       jump;
    logic       jalr;
    logic [1:0] utype;     // {LUI, AUIPC}
    logic [1:0] aluop;
    logic       alusrc;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regwrite;
    logic       muldiv;
  } ctrl_t;

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// Combinational RV32I decoder: instruction -> control bundle and register-use flags.
// Optional M-extension recognition is enabled by RV32M_EN.
module ctrl_decode
  import pipe_ctrl_unit_pkg::*;
(
  input  logic [31:0] inst,
  output ctrl_t       ctrl,
  output logic        use_rs1,
  output logic        use_rs2
);

  logic [6:0] opc;
  logic [6:0] funct7;
  logic is_r, is_i, is_l, is_s, is_b, is_jal, is_jalr, is_lui, is_auipc, known;
  logic unused_bits;

  assign opc    = inst[6:0];
  assign funct7 = inst[31:25];

  assign is_r     = (opc == OPCODE_R);
  assign is_i     = (opc == OPCODE_I);
  assign is_l     = (opc == OPCODE_L);
  assign is_s     = (opc == OPCODE_S);
  assign is_b     = (opc == OPCODE_B);
  assign is_jal   = (opc == OPCODE_JAL);
  assign is_jalr  = (opc == OPCODE_JALR);
  assign is_lui   = (opc == OPCODE_LUI);
  assign is_auipc = (opc == OPCODE_AUIPC);
  assign known    = is_r | is_i | is_l | is_s | is_b | is_jal | is_jalr | is_lui | is_auipc;

  // Register fields are consumed by the hazard logic in the parent, not here.
`ifdef RV32M_EN
  assign unused_bits = ^inst[24:7];
`else
  assign unused_bits = ^{funct7, inst[24:7]};
`endif

  always_comb begin
    ctrl          = '0;
    ctrl.branch   = is_b;
    ctrl.jump     = is_jal;
    ctrl.jalr     = is_jalr;
    ctrl.utype    = {is_lui, is_auipc};
    // ALUOp is gated by known so an unknown opcode yields an all-zero bundle.
    ctrl.aluop[1] = known & ~(is_l | is_s | is_b);
    ctrl.aluop[0] = known & ~(is_l | is_s | is_r);
    ctrl.alusrc   = is_i | is_l | is_s | is_lui | is_auipc;
    ctrl.memread  = is_l;
    ctrl.memwrite = is_s;
    ctrl.memtoreg = is_l;
    ctrl.regwrite = is_r | is_i | is_l | is_lui | is_auipc | is_jal | is_jalr;
`ifdef RV32M_EN
    ctrl.muldiv   = is_r & (funct7 == FUNCT7_MULDIV);
`else
    ctrl.muldiv   = 1'b0;
`endif
  end

  assign use_rs1 = is_r | is_i | is_l | is_s | is_b | is_jalr;
  assign use_rs2 = is_r | is_s | is_b;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control: ID decode registered into ID/EX, load-use stall, redirect flush and,
// when RV32M_EN is defined, a multi-cycle MUL/DIV hold of the ID/EX register.
module pipe_ctrl_unit
  import pipe_ctrl_unit_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MULDIV_LAT = 4,
  parameter int unsigned CNT_W      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] id_inst,
  input  logic        id_valid,
  input  logic        ex_redirect,
  output logic        pc_hold,
  output logic        if_id_flush,
  output logic        ex_valid,
  output logic [4:0]  ex_rd,
  output logic        ex_branch,
  output logic        ex_jump,
  output logic        ex_jalr,
  output logic [1:0]  ex_utype,
  output logic [1:0]  ex_aluop,
  output logic        ex_alusrc,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic        ex_memtoreg,
  output logic        ex_regwrite,
  output logic        ex_muldiv
);

  if (XLEN != 32) begin : g_xlen_chk
    $error("pipe_ctrl_unit: XLEN must be 32");
  end
  if (MULDIV_LAT < 1 || MULDIV_LAT > 15) begin : g_lat_chk
    $error("pipe_ctrl_unit: MULDIV_LAT must be 1..15");
  end
  if ((64'd1 << CNT_W) <= 64'(MULDIV_LAT)) begin : g_cnt_chk
    $error("pipe_ctrl_unit: 2**CNT_W must exceed MULDIV_LAT");
  end

  ctrl_t      dec;
  logic       use_rs1, use_rs2;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       load_use, md_busy;

  ctrl_t      ex_ctrl_q, ex_ctrl_d;
  logic       ex_valid_q, ex_valid_d;
  logic [4:0] ex_rd_q, ex_rd_d;

  ctrl_decode u_decode (
    .inst    (id_inst),
    .ctrl    (dec),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2)
  );

  assign id_rs1 = id_inst[19:15];
  assign id_rs2 = id_inst[24:20];
  assign id_rd  = id_inst[11:7];

  assign load_use = ex_valid_q & ex_ctrl_q.memread & (ex_rd_q != 5'd0) & id_valid &
                    ((use_rs1 & (id_rs1 == ex_rd_q)) | (use_rs2 & (id_rs2 == ex_rd_q)));

`ifdef RV32M_EN
  md_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign md_busy = (state_q == MD_BUSY);

  // Enter MD_BUSY on the same edge the MUL/DIV op is loaded into ID/EX.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (!ex_redirect && !load_use && id_valid && dec.muldiv && (MULDIV_LAT > 1)) begin
          state_d = MD_BUSY;
          cnt_d   = CNT_W'(MULDIV_LAT - 1);
        end
      end
      MD_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  assign md_busy = 1'b0;
`endif

  // A busy MUL/DIV outranks redirect: it cannot itself redirect, so the request is dropped.
  always_comb begin
    pc_hold     = 1'b0;
    if_id_flush = 1'b0;
    ex_ctrl_d   = ex_ctrl_q;
    ex_valid_d  = ex_valid_q;
    ex_rd_d     = ex_rd_q;
    if (md_busy) begin
      pc_hold = 1'b1;
    end else if (ex_redirect) begin
      if_id_flush = 1'b1;
      ex_ctrl_d   = '0;
      ex_valid_d  = 1'b0;
      ex_rd_d     = '0;
    end else if (load_use) begin
      pc_hold    = 1'b1;
      ex_ctrl_d  = '0;
      ex_valid_d = 1'b0;
      ex_rd_d    = '0;
    end else begin
      ex_valid_d = id_valid;
      ex_ctrl_d  = id_valid ? dec : '0;
      ex_rd_d    = id_valid ? id_rd : 5'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl_q  <= '0;
      ex_valid_q <= 1'b0;
      ex_rd_q    <= '0;
    end else begin
      ex_ctrl_q  <= ex_ctrl_d;
      ex_valid_q <= ex_valid_d;
      ex_rd_q    <= ex_rd_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_rd       = ex_rd_q;
  assign ex_branch   = ex_ctrl_q.branch;
  assign ex_jump     = ex_ctrl_q.jump;
  assign ex_jalr     = ex_ctrl_q.jalr;
  assign ex_utype    = ex_ctrl_q.utype;
  assign ex_aluop    = ex_ctrl_q.aluop;
  assign ex_alusrc   = ex_ctrl_q.alusrc;
  assign ex_memread  = ex_ctrl_q.memread;
  assign ex_memwrite = ex_ctrl_q.memwrite;
  assign ex_memtoreg = ex_ctrl_q.memtoreg;
  assign ex_regwrite = ex_ctrl_q.regwrite;
  assign ex_muldiv   = ex_ctrl_q.muldiv;

endmodule
